// File: rtl/dlfloat16_round_pack_if.sv
// Handshake bundle between the DLfloat16 extended-result producer, the
// round/pack stage and its writeback consumer, plus the sticky status port.
interface dlfloat16_round_pack_if;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_res;
   logic [4:0]  in_flags;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_res;
   logic [4:0]  out_flags;
   logic        flag_clr;
   logic [4:0]  sticky_flags;

   modport slave (
      input  in_valid, in_res, in_flags, out_ready, flag_clr,
      output in_ready, out_valid, out_res, out_flags, sticky_flags
   );

   modport master (
      output in_valid, in_res, in_flags, out_ready, flag_clr,
      input  in_ready, out_valid, out_res, out_flags, sticky_flags
   );
endinterface

// File: rtl/dlfloat16_round_pack.sv
// Rounds a 20-bit extended DLfloat16 result to nearest-even, repacks it to
// 16 bits and merges exception flags through a two-stage throttled pipeline.
module dlfloat16_round_pack (
   input logic                    clk,
   input logic                    rst_n,
   dlfloat16_round_pack_if.slave  io_rp
);
   localparam logic [4:0] FL_INEXACT   = 5'b01000;
   localparam logic [4:0] FL_OVERFLOW  = 5'b00100;
   localparam logic [4:0] FL_UNDERFLOW = 5'b00010;

   logic        w_sign;
   logic [5:0]  w_exp_in;
   logic [12:0] w_man_in;
   logic        w_guard;
   logic        w_sticky;
   logic        w_round_up;
   logic [9:0]  w_inc;
   logic [5:0]  w_exp;
   logic [8:0]  w_frac;
   logic [4:0]  w_raised;
   logic        w_finite;

   logic        r_s1_valid;
   logic        r_s1_sign;
   logic [5:0]  r_s1_exp;
   logic [8:0]  r_s1_frac;
   logic [4:0]  r_s1_flags;
   logic        r_s1_finite;

   logic        r_s2_valid;
   logic [15:0] r_out_res;
   logic [4:0]  r_out_flags;
   logic [4:0]  r_sticky;

   logic [15:0] w_pk_res;
   logic [4:0]  w_pk_flags;
   logic        w_s2_load;
   logic        w_in_fire;
   logic        w_out_fire;

   assign w_sign     = io_rp.in_res[19];
   assign w_exp_in   = io_rp.in_res[18:13];
   assign w_man_in   = io_rp.in_res[12:0];
   assign w_guard    = w_man_in[3];
   assign w_sticky   = |w_man_in[2:0];
   assign w_round_up = w_guard & (w_sticky | w_man_in[4]);

   // Stage 1: classify specials, flush zero-exponent inputs, round to nearest-even.
   always_comb begin
      w_exp    = w_exp_in;
      w_frac   = 9'h000;
      w_raised = 5'h00;
      w_finite = 1'b1;
      w_inc    = 10'h000;
      if (w_exp_in == 6'h3F) begin
         w_finite = 1'b0;
         w_frac   = (w_man_in[12:4] != 9'h000) ? 9'h1FF : 9'h000;
      end else if (w_exp_in == 6'h00) begin
         w_raised = (w_man_in[12:4] != 9'h000) ? (FL_UNDERFLOW | FL_INEXACT) : 5'h00;
      end else begin
         w_inc    = {1'b0, w_man_in[12:4]} + {9'h000, w_round_up};
         w_raised = (w_guard | w_sticky) ? FL_INEXACT : 5'h00;
         if (w_inc[9]) begin
            w_frac = 9'h000;
            w_exp  = w_exp_in + 6'h01;
         end else begin
            w_frac = w_inc[8:0];
            w_exp  = w_exp_in;
         end
      end
   end

   // Stage 2: a finite value rounded up into the top exponent becomes infinity.
   always_comb begin
      w_pk_res   = {r_s1_sign, r_s1_exp, r_s1_frac};
      w_pk_flags = r_s1_flags;
      if (r_s1_finite && (r_s1_exp == 6'h3F)) begin
         w_pk_res   = {r_s1_sign, 6'h3F, 9'h000};
         w_pk_flags = r_s1_flags | FL_OVERFLOW;
      end else begin
         w_pk_res   = {r_s1_sign, r_s1_exp, r_s1_frac};
         w_pk_flags = r_s1_flags;
      end
   end

   assign w_s2_load  = !r_s2_valid | io_rp.out_ready;
   assign w_in_fire  = io_rp.in_valid & io_rp.in_ready;
   assign w_out_fire = r_s2_valid & io_rp.out_ready;

   // Stage 1 register: refills on accept, empties when its entry moves on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_sign   <= 1'b0;
         r_s1_exp    <= 6'h00;
         r_s1_frac   <= 9'h000;
         r_s1_flags  <= 5'h00;
         r_s1_finite <= 1'b0;
      end else if (w_in_fire) begin
         r_s1_valid  <= 1'b1;
         r_s1_sign   <= w_sign;
         r_s1_exp    <= w_exp;
         r_s1_frac   <= w_frac;
         r_s1_flags  <= io_rp.in_flags | w_raised;
         r_s1_finite <= w_finite;
      end else if (w_s2_load) begin
         r_s1_valid  <= 1'b0;
      end
   end

   // Stage 2 register: output data only changes when the slot is free or drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid  <= 1'b0;
         r_out_res   <= 16'h0000;
         r_out_flags <= 5'h00;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_res   <= w_pk_res;
            r_out_flags <= w_pk_flags;
         end
      end
   end

   // Sticky status: flags of a transfer in the clearing cycle survive the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= 5'h00;
      end else begin
         r_sticky <= (io_rp.flag_clr ? 5'h00 : r_sticky) |
                     (w_out_fire ? r_out_flags : 5'h00);
      end
   end

   assign io_rp.in_ready     = !r_s1_valid | w_s2_load;
   assign io_rp.out_valid    = r_s2_valid;
   assign io_rp.out_res      = r_out_res;
   assign io_rp.out_flags    = r_out_flags;
   assign io_rp.sticky_flags = r_sticky;
endmodule
